// File: rtl/nes_pad_reader.sv
// nes_pad_reader
//   Console-side reader for the Famicom/NES serial game-controller protocol.
//   It drives the latch and pulse lines, shifts in the serial data line and
//   presents the result as an active-high button word with a one-cycle
//   valid strobe. A scan runs on request (start) or, when POLL_PERIOD > 0,
//   automatically every POLL_PERIOD cycles.
//
//   Ports
//     clk_sys   in   system clock
//     reset_n   in   asynchronous active-low reset
//     start     in   scan request, sampled only while idle
//     pad_data  in   serial data from the pad (active-low, asynchronous)
//     pad_latch out  latch line to the pad (active-high, registered)
//     pad_pulse out  clock line to the pad (pad shifts on its falling edge)
//     buttons   out  last completed scan, bit i = i-th serial bit, active-high
//     valid     out  one-cycle strobe, buttons change in the same cycle
//     busy      out  high while a scan is in progress
//
//   Handshake: start is a level request that is consumed on the first clock
//   edge at which the reader is idle; requests while busy are dropped.
//   valid is a single-cycle qualifier for buttons with no back-pressure.
module nes_pad_reader #(
    parameter int CLK_DIV     = 4,
    parameter int NUM_BITS    = 8,
    parameter int POLL_PERIOD = 0
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                start,
    input  logic                pad_data,
    output logic                pad_latch,
    output logic                pad_pulse,
    output logic [NUM_BITS-1:0] buttons,
    output logic                valid,
    output logic                busy
);

    localparam int HW = $clog2(2 * CLK_DIV);
    localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
    localparam logic [HW-1:0] L_LAST = HW'(2 * CLK_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(NUM_BITS - 1);
    localparam logic [PW-1:0] P_LAST = PW'((POLL_PERIOD > 0) ? POLL_PERIOD - 1 : 0);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LATCH    = 3'd1;
    localparam logic [2:0] S_GAP      = 3'd2;
    localparam logic [2:0] S_PULSE_HI = 3'd3;
    localparam logic [2:0] S_PULSE_LO = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [HW-1:0]       h_q, h_d;
    logic [BW-1:0]       b_q, b_d;
    logic [PW-1:0]       poll_q, poll_d;
    logic                pending_q, pending_d;
    logic [NUM_BITS-1:0] shift_q, shift_d;
    logic [NUM_BITS-1:0] buttons_q, buttons_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                latch_q, latch_d;
    logic                pulse_q, pulse_d;
    logic                sync1_q, sync2_q;
    logic                accept;
    logic                wrap;

    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        b_d       = b_q;
        shift_d   = shift_q;
        buttons_d = buttons_q;
        valid_d   = 1'b0;
        accept    = 1'b0;
        wrap      = (POLL_PERIOD > 0) && (poll_q == P_LAST);
        poll_d    = (POLL_PERIOD == 0 || wrap) ? '0 : poll_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start || pending_q) begin
                    accept  = 1'b1;
                    state_d = S_LATCH;
                    h_d     = '0;
                    b_d     = '0;
                end
            end
            S_LATCH: begin
                if (h_q == L_LAST) begin
                    state_d = S_GAP;
                    h_d     = '0;
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
            S_GAP: begin
                // Bit 0 is presented by the pad as soon as it is latched.
                if (h_q == H_LAST) begin
                    shift_d[0] = ~sync2_q;
                    b_d        = BW'(1);
                    h_d        = '0;
                    state_d    = (NUM_BITS == 1) ? S_DONE : S_PULSE_HI;
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
            S_PULSE_HI: begin
                if (h_q == H_LAST) begin
                    state_d = S_PULSE_LO;
                    h_d     = '0;
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
            S_PULSE_LO: begin
                // The pad shifted on the falling edge that opened this phase;
                // sampling at its end leaves time for the synchroniser.
                if (h_q == H_LAST) begin
                    shift_d[b_q] = ~sync2_q;
                    h_d          = '0;
                    if (b_q == B_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        b_d     = b_q + 1'b1;
                        state_d = S_PULSE_HI;
                    end
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
            S_DONE: begin
                buttons_d = shift_q;
                valid_d   = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A wrap coinciding with an accepted start must not leave a second
        // request behind.
        pending_d = pending_q;
        if (accept)
            pending_d = 1'b0;
        if (wrap && !accept)
            pending_d = 1'b1;

        // busy stays up through the valid cycle so it falls one cycle later.
        busy_d  = (state_d != S_IDLE) || valid_d;
        latch_d = (state_d == S_LATCH);
        pulse_d = (state_d == S_PULSE_HI);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            h_q       <= '0;
            b_q       <= '0;
            poll_q    <= '0;
            pending_q <= 1'b0;
            shift_q   <= '0;
            buttons_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            latch_q   <= 1'b0;
            pulse_q   <= 1'b0;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            b_q       <= b_d;
            poll_q    <= poll_d;
            pending_q <= pending_d;
            shift_q   <= shift_d;
            buttons_q <= buttons_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            latch_q   <= latch_d;
            pulse_q   <= pulse_d;
            sync1_q   <= pad_data;
            sync2_q   <= sync1_q;
        end
    end

    assign pad_latch = latch_q;
    assign pad_pulse = pulse_q;
    assign buttons   = buttons_q;
    assign valid     = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader
//   Directed bench for nes_pad_reader. Instance A (CLK_DIV=4, NUM_BITS=8,
//   no auto-poll) is driven by start; instance B (NUM_BITS=24,
//   POLL_PERIOD=200) polls on its own. Each instance talks to a behavioural
//   shift-register pad that loads the inverted pressed word while latch is
//   high and shifts in released (1) bits on each falling edge of pulse.
module tb_nes_pad_reader;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // instance A
    logic        start_a = 1'b0;
    logic        pad_data_a;
    logic        latch_a, pulse_a, valid_a, busy_a;
    logic [7:0]  buttons_a;
    logic [7:0]  pressed_a = 8'h00;
    logic [7:0]  sr_a = 8'hFF;
    logic        prev_pulse_a = 1'b0;
    int          tie_a = 0;    // 0: responder, 1: tied high, 2: tied low

    // instance B
    logic        start_b = 1'b0;
    logic        pad_data_b;
    logic        latch_b, pulse_b, valid_b, busy_b;
    logic [23:0] buttons_b;
    logic [23:0] pressed_b = 24'h000080;
    logic [23:0] sr_b = 24'hFFFFFF;
    logic        prev_pulse_b = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    nes_pad_reader #(.CLK_DIV(4), .NUM_BITS(8), .POLL_PERIOD(0)) dut_a (
        .clk_sys(clk), .reset_n(reset_n), .start(start_a), .pad_data(pad_data_a),
        .pad_latch(latch_a), .pad_pulse(pulse_a), .buttons(buttons_a),
        .valid(valid_a), .busy(busy_a)
    );

    nes_pad_reader #(.CLK_DIV(4), .NUM_BITS(24), .POLL_PERIOD(200)) dut_b (
        .clk_sys(clk), .reset_n(reset_n), .start(start_b), .pad_data(pad_data_b),
        .pad_latch(latch_b), .pad_pulse(pulse_b), .buttons(buttons_b),
        .valid(valid_b), .busy(busy_b)
    );

    // pad responders
    always @(posedge clk) begin
        if (latch_a)
            sr_a <= ~pressed_a;
        else if (prev_pulse_a && !pulse_a)
            sr_a <= {1'b1, sr_a[7:1]};
        prev_pulse_a <= pulse_a;
    end
    assign pad_data_a = (tie_a == 1) ? 1'b1 : (tie_a == 2) ? 1'b0 : sr_a[0];

    always @(posedge clk) begin
        if (latch_b)
            sr_b <= ~pressed_b;
        else if (prev_pulse_b && !pulse_b)
            sr_b <= {1'b1, sr_b[23:1]};
        prev_pulse_b <= pulse_b;
    end
    assign pad_data_b = sr_b[0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues start for one cycle and watches instance A for 'window' cycles.
    // n counts clock edges after the accepting edge; samples are taken on the
    // falling edge. A second start is pulsed when pulse number restart_pulse rises.
    task automatic run_scan_a(input int restart_pulse, input int window,
                              output int lat, output int pulses, output int pulse_hi,
                              output int valid_n, output int valid_cnt, output int busy_fall);
        logic prev_p;
        lat = 0; pulses = 0; pulse_hi = 0; valid_n = -1; valid_cnt = 0; busy_fall = -1;
        prev_p = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        for (int n = 0; n < window; n++) begin
            if (start_a) start_a = 1'b0;
            if (latch_a) lat++;
            if (pulse_a) pulse_hi++;
            if (pulse_a && !prev_p) begin
                pulses++;
                if (pulses == restart_pulse) start_a = 1'b1;
            end
            prev_p = pulse_a;
            if (valid_a) begin
                valid_cnt++;
                if (valid_n < 0) valid_n = n;
            end
            if (valid_n >= 0 && busy_fall < 0 && !busy_a) busy_fall = n;
            @(negedge clk);
        end
        start_a = 1'b0;
    endtask

    task automatic wait_valid_b(input int bound, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!valid_b && cycles < bound);
        if (!valid_b) cycles = -1;
    endtask

    initial begin
        int lat, pulses, pulse_hi, valid_n, valid_cnt, busy_fall;
        int found, rises, cyc;
        logic prev_p;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_latch", {31'd0, latch_a}, 32'd0);
        check("rst_pulse", {31'd0, pulse_a}, 32'd0);
        check("rst_buttons", {24'd0, buttons_a}, 32'd0);
        check("rst_valid_busy", {30'd0, valid_a, busy_a}, 32'd0);
        check("rst_b_buttons", {8'd0, buttons_b}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // single scan, A pressed
        pressed_a = 8'h01;
        run_scan_a(0, 100, lat, pulses, pulse_hi, valid_n, valid_cnt, busy_fall);
        check("s1_latch_cycles", lat, 8);
        check("s1_pulse_count", pulses, 7);
        check("s1_pulse_hi_cycles", pulse_hi, 28);
        check("s1_valid_edge", valid_n, 69);
        check("s1_valid_count", valid_cnt, 1);
        check("s1_busy_fall", busy_fall, 70);
        check("s1_buttons", {24'd0, buttons_a}, 32'h01);

        // pattern
        pressed_a = 8'hA5;
        run_scan_a(0, 100, lat, pulses, pulse_hi, valid_n, valid_cnt, busy_fall);
        check("pat_buttons", {24'd0, buttons_a}, 32'hA5);
        check("pat_valid_count", valid_cnt, 1);

        // stuck lines
        tie_a = 1;
        run_scan_a(0, 100, lat, pulses, pulse_hi, valid_n, valid_cnt, busy_fall);
        check("tie_high_buttons", {24'd0, buttons_a}, 32'h00);
        tie_a = 2;
        run_scan_a(0, 100, lat, pulses, pulse_hi, valid_n, valid_cnt, busy_fall);
        check("tie_low_buttons", {24'd0, buttons_a}, 32'hFF);
        tie_a = 0;

        // start during the third pulse is ignored
        pressed_a = 8'h5A;
        run_scan_a(3, 170, lat, pulses, pulse_hi, valid_n, valid_cnt, busy_fall);
        check("busy_valid_count", valid_cnt, 1);
        check("busy_pulse_count", pulses, 7);
        check("busy_valid_edge", valid_n, 69);
        check("busy_fall", busy_fall, 70);
        check("busy_buttons", {24'd0, buttons_a}, 32'h5A);

        // reset during the fourth pulse (after three complete pulses)
        pressed_a = 8'hA5;
        run_scan_a(0, 100, lat, pulses, pulse_hi, valid_n, valid_cnt, busy_fall);
        check("pre_rst_buttons", {24'd0, buttons_a}, 32'hA5);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        found = 0; rises = 0; prev_p = 1'b0;
        for (int n = 0; n < 100 && found == 0; n++) begin
            if (pulse_a && !prev_p) rises++;
            prev_p = pulse_a;
            if (rises == 4) found = 1;
            else @(negedge clk);
        end
        check("mid_reach_pulse4", found, 1);
        check("mid_pulse_before", {31'd0, pulse_a}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_pulse", {31'd0, pulse_a}, 32'd0);
        check("mid_rst_latch", {31'd0, latch_a}, 32'd0);
        check("mid_rst_buttons", {24'd0, buttons_a}, 32'd0);
        check("mid_rst_valid_busy", {30'd0, valid_a, busy_a}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_hold", {20'd0, latch_a, pulse_a, valid_a, busy_a, buttons_a}, 32'd0);
        reset_n = 1'b1;
        run_scan_a(0, 100, lat, pulses, pulse_hi, valid_n, valid_cnt, busy_fall);
        check("post_rst_buttons", {24'd0, buttons_a}, 32'hA5);
        check("post_rst_valid_count", valid_cnt, 1);

        // auto-poll on instance B
        wait_valid_b(700, cyc);
        check("poll_first_seen", {31'd0, (cyc > 0)}, 32'd1);
        check("poll_first_buttons", {8'd0, buttons_b}, 32'h000080);
        wait_valid_b(400, cyc);
        check("poll_interval_1", cyc, 200);
        check("poll_buttons_1", {8'd0, buttons_b}, 32'h000080);
        pressed_b = 24'h00003C;
        wait_valid_b(400, cyc);
        check("poll_interval_2", cyc, 200);
        check("poll_buttons_3c", {8'd0, buttons_b}, 32'h00003C);
        check("poll_no_overlap", {30'd0, latch_b, pulse_b}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
